// File: rtl/nv_ddr_pkg.sv
// rtl/nv_ddr_pkg.sv - shared state encoding and command-word layout for nv_ddr_host
package nv_ddr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPEN,
    ST_BEAT,
    ST_CLOSE,
    ST_SETTLE,
    ST_SLEEP
  } state_e;

  localparam int RD_BIT   = 17;
  localparam int WR_BIT   = 16;
  localparam int COL_MSB  = 15;
  localparam int COL_LSB  = 12;
  localparam int ROW_MSB  = 11;
  localparam int ROW_LSB  = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;
  localparam int CMD_W    = RD_BIT + 1;

  localparam int SESSION_BEATS_DEF = 16;

endpackage

// File: rtl/nv_ddr_host_if.sv
// rtl/nv_ddr_host_if.sv - client and memory signals of nv_ddr_host; NV_DDR_HOST_PWRDN_EN adds power-down pins
interface nv_ddr_host_if
  import nv_ddr_pkg::*;
#(
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [3:0]        req_row;
  logic [3:0]        req_col;
  logic [3:0]        req_len_m1;
  logic [DATA_W-1:0] wdata;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              rdata_last;
  logic              busy;
  logic [CMD_W-1:0]  mem_user_data;
  logic              mem_enable;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic              mem_power_enable;
  logic [DATA_W-1:0] mem_user_out;
`ifdef NV_DDR_HOST_PWRDN_EN
  logic              pwr_dn_req;
  logic              sleeping;
`endif

  modport slave (
    input  req_valid, req_write, req_row, req_col, req_len_m1,
    input  wdata, wdata_valid, mem_user_out,
`ifdef NV_DDR_HOST_PWRDN_EN
    input  pwr_dn_req,
    output sleeping,
`endif
    output req_ready, wdata_ready, rdata, rdata_valid, rdata_last, busy,
    output mem_user_data, mem_enable, mem_rd_en, mem_wr_en, mem_power_enable
  );

  modport master (
    output req_valid, req_write, req_row, req_col, req_len_m1,
    output wdata, wdata_valid, mem_user_out,
`ifdef NV_DDR_HOST_PWRDN_EN
    output pwr_dn_req,
    input  sleeping,
`endif
    input  req_ready, wdata_ready, rdata, rdata_valid, rdata_last, busy,
    input  mem_user_data, mem_enable, mem_rd_en, mem_wr_en, mem_power_enable
  );

endinterface

// File: rtl/nv_ddr_beat_gen.sv
// rtl/nv_ddr_beat_gen.sv - beat/active counters and wrapping {row,col} address for one session
module nv_ddr_beat_gen
  import nv_ddr_pkg::*;
#(
  parameter int SESSION_BEATS = SESSION_BEATS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       beat_i,
  input  logic       write_i,
  input  logic       wvalid_i,
  input  logic [7:0] base_i,
  input  logic [3:0] len_m1_i,
  output logic [7:0] addr_o,
  output logic       pad_o,
  output logic       last_o,
  output logic       take_o,
  output logic       done_o
);
  localparam int CNT_W = $clog2(SESSION_BEATS + 1);

  logic [CNT_W-1:0] beat_cnt_q;
  logic [CNT_W-1:0] act_cnt_q;
  logic [7:0]       addr_q;
  logic             active;

  assign addr_o = addr_q;
  assign pad_o  = beat_cnt_q > CNT_W'(len_m1_i);
  assign last_o = beat_cnt_q == CNT_W'(len_m1_i);
  assign take_o = beat_i & ~pad_o & (~write_i | wvalid_i);
  // Write padding is always active; a stalled real write beat is not.
  assign active = beat_i & (~write_i | pad_o | wvalid_i);
  assign done_o = active & (act_cnt_q == CNT_W'(SESSION_BEATS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt_q <= '0;
      act_cnt_q  <= '0;
      addr_q     <= '0;
    end else if (load_i) begin
      beat_cnt_q <= '0;
      act_cnt_q  <= '0;
      addr_q     <= base_i;
    end else begin
      if (active) act_cnt_q <= act_cnt_q + 1'b1;
      if (take_o) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
        // Holding on the final real beat makes padding reuse that address.
        if (!last_o) addr_q <= addr_q + 8'd1;
      end
    end
  end

endmodule

// File: rtl/nv_ddr_host.sv
// rtl/nv_ddr_host.sv - turns client bursts into fixed-length NV DDR sessions; NV_DDR_HOST_PWRDN_EN adds SLEEP
module nv_ddr_host
  import nv_ddr_pkg::*;
#(
  parameter int SESSION_BEATS = SESSION_BEATS_DEF,
  parameter int DATA_W        = 8
) (
  input  logic         clk,
  input  logic         rst,
  nv_ddr_host_if.slave bus
);
  state_e            state_q, state_d;
  logic              write_q;
  logic [7:0]        base_q;
  logic [3:0]        len_q;
  logic              mem_enable_q, mem_rd_en_q, mem_wr_en_q, busy_q, req_ready_q;
  logic              rdata_valid_q, rdata_last_q;
  logic [DATA_W-1:0] last_wdata_q;
  logic [CMD_W-1:0]  cmd;
  logic              wready;
  logic [7:0]        addr;
  logic              pad, last, take, done, in_beat, accept, in_session;

  assign in_beat = state_q == ST_BEAT;
  assign accept  = (state_q == ST_IDLE) & bus.req_valid & bus.req_ready;

`ifdef NV_DDR_HOST_PWRDN_EN
  logic pend_q, sleeping_q, mem_power_enable_q;
  logic pwr_dn;
  assign pwr_dn               = bus.pwr_dn_req | pend_q;
  assign bus.req_ready        = req_ready_q & ~bus.pwr_dn_req;
  assign bus.sleeping         = sleeping_q;
  assign bus.mem_power_enable = mem_power_enable_q;
`else
  assign bus.req_ready        = req_ready_q;
  assign bus.mem_power_enable = 1'b1;
`endif

  nv_ddr_beat_gen #(.SESSION_BEATS(SESSION_BEATS)) u_beat_gen (
    .clk      (clk),
    .rst      (rst),
    .load_i   (state_q == ST_OPEN),
    .beat_i   (in_beat),
    .write_i  (write_q),
    .wvalid_i (bus.wdata_valid),
    .base_i   (base_q),
    .len_m1_i (len_q),
    .addr_o   (addr),
    .pad_o    (pad),
    .last_o   (last),
    .take_o   (take),
    .done_o   (done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
`ifdef NV_DDR_HOST_PWRDN_EN
      ST_IDLE:   if (pwr_dn) state_d = ST_SLEEP; else if (accept) state_d = ST_OPEN;
      ST_SLEEP:  state_d = ST_SLEEP;
`else
      ST_IDLE:   if (accept) state_d = ST_OPEN;
`endif
      ST_OPEN:   state_d = ST_BEAT;
      ST_BEAT:   if (done) state_d = ST_CLOSE;
      ST_CLOSE:  state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign in_session = state_d inside {ST_OPEN, ST_BEAT, ST_CLOSE, ST_SETTLE};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      write_q       <= 1'b0;
      base_q        <= '0;
      len_q         <= '0;
      mem_enable_q  <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      busy_q        <= 1'b0;
      req_ready_q   <= 1'b1;
      rdata_valid_q <= 1'b0;
      rdata_last_q  <= 1'b0;
      last_wdata_q  <= '0;
`ifdef NV_DDR_HOST_PWRDN_EN
      pend_q             <= 1'b0;
      sleeping_q         <= 1'b0;
      mem_power_enable_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q <= bus.req_write;
        base_q  <= {bus.req_row, bus.req_col};
        len_q   <= bus.req_len_m1;
      end
      if (take && write_q) last_wdata_q <= bus.wdata;
      mem_enable_q  <= in_session;
      busy_q        <= in_session;
      mem_wr_en_q   <= accept & bus.req_write;
      mem_rd_en_q   <= accept & ~bus.req_write;
      rdata_valid_q <= take & ~write_q;
      rdata_last_q  <= take & ~write_q & last;
`ifdef NV_DDR_HOST_PWRDN_EN
      pend_q             <= pend_q | bus.pwr_dn_req;
      req_ready_q        <= (state_d == ST_IDLE) & ~pend_q & ~bus.pwr_dn_req;
      sleeping_q         <= state_d == ST_SLEEP;
      mem_power_enable_q <= state_d != ST_SLEEP;
`else
      req_ready_q   <= state_d == ST_IDLE;
`endif
    end
  end

  always_comb begin
    cmd    = '0;
    wready = 1'b0;
    if (in_beat) begin
      cmd[COL_MSB:COL_LSB] = addr[3:0];
      cmd[ROW_MSB:ROW_LSB] = addr[7:4];
      if (!write_q) begin
        cmd[RD_BIT] = 1'b1;
      end else if (pad) begin
        cmd[WR_BIT]            = 1'b1;
        cmd[DATA_MSB:DATA_LSB] = last_wdata_q;
      end else if (bus.wdata_valid) begin
        cmd[WR_BIT]            = 1'b1;
        cmd[DATA_MSB:DATA_LSB] = bus.wdata;
        wready                 = 1'b1;
      end
    end
  end

  assign bus.mem_user_data = cmd;
  assign bus.wdata_ready   = wready;
  assign bus.mem_enable    = mem_enable_q;
  assign bus.mem_rd_en     = mem_rd_en_q;
  assign bus.mem_wr_en     = mem_wr_en_q;
  assign bus.busy          = busy_q;
  assign bus.rdata_valid   = rdata_valid_q;
  assign bus.rdata_last    = rdata_last_q;
  assign bus.rdata         = rdata_valid_q ? bus.mem_user_out : '0;

endmodule

// File: tb/tb_nv_ddr_host.sv
// tb/tb_nv_ddr_host.sv - directed bench for nv_ddr_host with a behavioural 16x16x8 memory
module tb_nv_ddr_host;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nv_ddr_host_if #(.DATA_W(8)) bus ();
  nv_ddr_host #(.SESSION_BEATS(16), .DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] mem [256];
  always @(posedge clk or negedge rst) begin
    if (!rst) bus.mem_user_out <= '0;
    else if (bus.mem_enable) begin
      if (bus.mem_user_data[16]) mem[{bus.mem_user_data[11:8], bus.mem_user_data[15:12]}] <= bus.mem_user_data[7:0];
      if (bus.mem_user_data[17]) bus.mem_user_out <= mem[{bus.mem_user_data[11:8], bus.mem_user_data[15:12]}];
    end
  end

  int n_pass = 0;
  int n_checks = 0;
  logic [17:0] cmd_log[$];
  logic [7:0]  rd_data[$];
  logic        rd_last[$];
  logic [7:0]  wq[16];
  int sess_cycles, n_wready, n_quiet, last_act;
  logic open_ok;

  task automatic run_session(input logic wr, input logic [3:0] row, input logic [3:0] col,
                             input logic [3:0] len, input int gap_at, input int gap_n);
    int k = 0;
    int idle_left = gap_n;
    cmd_log.delete(); rd_data.delete(); rd_last.delete();
    sess_cycles = -1; n_wready = 0; n_quiet = 0; last_act = -1; open_ok = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_row = row; bus.req_col = col; bus.req_len_m1 = len;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (wr && k <= int'(len) && !(k == gap_at && idle_left > 0)) begin
        bus.wdata_valid = 1'b1;
        bus.wdata = wq[k];
      end else begin
        bus.wdata_valid = 1'b0;
        if (wr && k == gap_at && idle_left > 0) idle_left--;
      end
      #1;
      if (cyc == 1)
        open_ok = bus.busy && bus.mem_enable && !bus.req_ready && bus.mem_wr_en == wr && bus.mem_rd_en == !wr;
      if (bus.wdata_ready) begin n_wready++; k++; end
      if (bus.mem_enable && (bus.mem_user_data[17] || bus.mem_user_data[16])) begin
        cmd_log.push_back(bus.mem_user_data);
        last_act = cyc;
      end else if (bus.mem_enable) n_quiet++;
      if (bus.rdata_valid) begin rd_data.push_back(bus.rdata); rd_last.push_back(bus.rdata_last); end
      if (bus.req_ready) begin sess_cycles = cyc; break; end
      @(negedge clk);
    end
    bus.wdata_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_checks++;
    if ({bus.req_ready, bus.mem_power_enable, bus.busy, bus.mem_enable, bus.mem_rd_en, bus.mem_wr_en,
         bus.rdata_valid, bus.rdata_last, bus.wdata_ready} !== 9'b110000000)
      $display("FAIL reset_flags: got %b want 110000000", {bus.req_ready, bus.mem_power_enable, bus.busy,
               bus.mem_enable, bus.mem_rd_en, bus.mem_wr_en, bus.rdata_valid, bus.rdata_last, bus.wdata_ready});
    else n_pass++;
    n_checks++;
    if (bus.mem_user_data !== 18'h0 || bus.rdata !== 8'h0)
      $display("FAIL reset_data: cmd %h rdata %h want 0", bus.mem_user_data, bus.rdata);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_write_short();
    int bad = 0;
    wq[0] = 8'hA1; wq[1] = 8'hA2; wq[2] = 8'hA3;
    run_session(1'b1, 4'd2, 4'd14, 4'd2, -1, 0);
    n_checks++;
    if (!open_ok) $display("FAIL ws_open: OPEN cycle flags wrong, got 0 want 1"); else n_pass++;
    n_checks++;
    if (cmd_log.size() != 16) $display("FAIL ws_beats: got %0d want 16", cmd_log.size()); else n_pass++;
    n_checks++;
    if (cmd_log[0] !== 18'h1E2A1 || cmd_log[1] !== 18'h1F2A2 || cmd_log[2] !== 18'h103A3)
      $display("FAIL ws_real: got %h %h %h want 1e2a1 1f2a2 103a3", cmd_log[0], cmd_log[1], cmd_log[2]);
    else n_pass++;
    for (int i = 3; i < 16; i++) if (i >= cmd_log.size() || cmd_log[i] !== 18'h103A3) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL ws_pad: got %0d bad padding beats want 0", bad); else n_pass++;
    n_checks++;
    if (n_wready != 3 || sess_cycles != 20 || n_quiet != 3)
      $display("FAIL ws_timing: wready %0d cycles %0d quiet %0d want 3 20 3", n_wready, sess_cycles, n_quiet);
    else n_pass++;
  endtask

  task automatic test_read_back();
    int bad = 0;
    run_session(1'b0, 4'd2, 4'd14, 4'd2, -1, 0);
    n_checks++;
    if (!open_ok) $display("FAIL rb_open: OPEN cycle flags wrong, got 0 want 1"); else n_pass++;
    n_checks++;
    if (rd_data.size() != 3) $display("FAIL rb_count: got %0d want 3", rd_data.size());
    else if ({rd_data[0], rd_data[1], rd_data[2]} !== 24'hA1A2A3 || {rd_last[0], rd_last[1], rd_last[2]} !== 3'b001)
      $display("FAIL rb_data: got %h %h %h last %b%b%b want a1 a2 a3 last 001",
               rd_data[0], rd_data[1], rd_data[2], rd_last[0], rd_last[1], rd_last[2]);
    else n_pass++;
    for (int i = 0; i < 16; i++) if (i >= cmd_log.size() || cmd_log[i][17:16] !== 2'b10) bad++;
    n_checks++;
    if (cmd_log.size() != 16 || bad != 0 || cmd_log[15][15:8] !== 8'h03)
      $display("FAIL rb_cmds: size %0d bad %0d last addr %h want 16 0 03", cmd_log.size(), bad, cmd_log[15][15:8]);
    else n_pass++;
  endtask

  task automatic test_full_wrap();
    int bad = 0;
    logic [7:0] a;
    for (int i = 0; i < 16; i++) wq[i] = 8'h10 + 8'(i);
    run_session(1'b1, 4'd15, 4'd15, 4'd15, -1, 0);
    for (int i = 0; i < 16; i++) begin
      a = 8'hFF + 8'(i);
      if (i >= cmd_log.size() || cmd_log[i] !== {2'b01, a[3:0], a[7:4], wq[i]}) bad++;
    end
    n_checks++;
    if (cmd_log.size() != 16 || bad != 0) $display("FAIL fw_addr: size %0d bad %0d want 16 0", cmd_log.size(), bad);
    else n_pass++;
    n_checks++;
    if (last_act != 17 || sess_cycles != 20 || n_wready != 16)
      $display("FAIL fw_close: last beat %0d cycles %0d wready %0d want 17 20 16", last_act, sess_cycles, n_wready);
    else n_pass++;
  endtask

  task automatic test_write_gap();
    int bad = 0;
    for (int i = 0; i < 16; i++) wq[i] = 8'h40 + 8'(i);
    run_session(1'b1, 4'd6, 4'd0, 4'd15, 5, 3);
    for (int i = 0; i < 16; i++)
      if (i >= cmd_log.size() || cmd_log[i] !== {2'b01, 4'(i), 4'd6, wq[i]}) bad++;
    n_checks++;
    if (cmd_log.size() != 16 || bad != 0) $display("FAIL wg_beats: size %0d bad %0d want 16 0", cmd_log.size(), bad);
    else n_pass++;
    n_checks++;
    if (sess_cycles != 23 || n_quiet != 6)
      $display("FAIL wg_timing: cycles %0d quiet %0d want 23 6", sess_cycles, n_quiet);
    else n_pass++;
  endtask

  task automatic test_read_len0();
    int bad = 0;
    run_session(1'b0, 4'd5, 4'd5, 4'd0, -1, 0);
    n_checks++;
    if (rd_data.size() != 1) $display("FAIL r0_count: got %0d want 1", rd_data.size());
    else if (rd_last[0] !== 1'b1) $display("FAIL r0_last: got %b want 1", rd_last[0]);
    else n_pass++;
    for (int i = 0; i < 16; i++) if (i >= cmd_log.size() || cmd_log[i][17:8] !== 10'h255) bad++;
    n_checks++;
    if (cmd_log.size() != 16 || bad != 0 || sess_cycles != 20)
      $display("FAIL r0_cmds: size %0d bad %0d cycles %0d want 16 0 20", cmd_log.size(), bad, sess_cycles);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_row = 4'd6; bus.req_col = 4'd0; bus.req_len_m1 = 4'd15;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    n_checks++;
    if (!(bus.busy && bus.rdata_valid && bus.mem_user_data[17]))
      $display("FAIL rm_active: busy %b rvalid %b rd %b want 1 1 1", bus.busy, bus.rdata_valid, bus.mem_user_data[17]);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.req_ready, bus.mem_power_enable, bus.busy, bus.mem_enable, bus.mem_rd_en, bus.mem_wr_en,
         bus.rdata_valid, bus.rdata_last, bus.wdata_ready} !== 9'b110000000 || bus.mem_user_data !== 18'h0)
      $display("FAIL rm_async: flags %b cmd %h want 110000000 0", {bus.req_ready, bus.mem_power_enable, bus.busy,
               bus.mem_enable, bus.mem_rd_en, bus.mem_wr_en, bus.rdata_valid, bus.rdata_last, bus.wdata_ready},
               bus.mem_user_data);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.rdata_valid !== 1'b0 || bus.mem_enable !== 1'b0)
      $display("FAIL rm_hold: rvalid %b mem_enable %b want 0 0", bus.rdata_valid, bus.mem_enable);
    else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_after_reset();
    run_session(1'b0, 4'd2, 4'd14, 4'd2, -1, 0);
    n_checks++;
    if (rd_data.size() != 3 || sess_cycles != 20)
      $display("FAIL ar_count: got %0d beats %0d cycles want 3 20", rd_data.size(), sess_cycles);
    else if ({rd_data[0], rd_data[1], rd_data[2]} !== 24'hA1A2A3 || rd_last[2] !== 1'b1)
      $display("FAIL ar_data: got %h %h %h last %b want a1 a2 a3 1", rd_data[0], rd_data[1], rd_data[2], rd_last[2]);
    else n_pass++;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_row = '0; bus.req_col = '0; bus.req_len_m1 = '0;
    bus.wdata = '0; bus.wdata_valid = 1'b0;
`ifdef NV_DDR_HOST_PWRDN_EN
    bus.pwr_dn_req = 1'b0;
`endif
    test_reset();
    test_write_short();
    test_read_back();
    test_full_wrap();
    test_write_gap();
    test_read_len0();
    test_reset_mid();
    test_after_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/nv_ddr_host.md
Name: nv_ddr_host

Overview:
- Initiator-side sequencer for the team's 16x16x8 NV DDR memory model.
- Accepts burst read/write requests from a client (valid/ready) and a write-data stream.
- Converts each request into one complete memory session: open, exactly 16 active beats, close, settle. This keeps the memory's internal beat counters consistent.
- Returns read data to the client with valid/last flags.

Parameters:
- SESSION_BEATS, 16: active beats per session; must equal the memory's beat limit.
- DATA_W, 8: data width of the memory and client data.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-low.
- req_valid, input, 1: request valid.
- req_ready, output, 1: host can accept a request.
- req_write, input, 1: 1 = write burst, 0 = read burst.
- req_row, input, 4: start row.
- req_col, input, 4: start column.
- req_len_m1, input, 4: burst length minus 1 (1..16 beats).
- wdata, input, DATA_W: write data.
- wdata_valid, input, 1: write data valid.
- wdata_ready, output, 1: write data accepted this cycle.
- rdata, output, DATA_W: read data.
- rdata_valid, output, 1: rdata valid.
- rdata_last, output, 1: final beat of the burst.
- busy, output, 1: session in progress.
- mem_user_data, output, 18: memory command word. [17] = rd, [16] = wr, [15:12] = col, [11:8] = row, [7:0] = data.
- mem_enable, output, 1: memory enable.
- mem_rd_en, output, 1: open a read session.
- mem_wr_en, output, 1: open a write session.
- mem_power_enable, output, 1: memory power enable.
- mem_user_out, input, DATA_W: memory read data.

Behaviour:
- Reset values: all outputs 0 except mem_power_enable = 1 and req_ready = 1. State is IDLE; all counters are 0.
- Reset mid-session: the session is abandoned with no further beats and no rdata. The memory is reset on the same line.
- States: IDLE, OPEN, BEAT, CLOSE, SETTLE (plus SLEEP with the optional feature).
- IDLE:
  - mem_enable = 0, busy = 0, req_ready = 1.
  - On req_valid and req_ready, latch write, row, col and len_m1, then go to OPEN.
- OPEN (1 cycle):
  - mem_enable = 1; mem_wr_en = req_write; mem_rd_en = not req_write.
  - mem_user_data rd/wr bits = 0.
  - Next state BEAT; beat_cnt = 0, act_cnt = 0.
- BEAT:
  - mem_enable = 1, rd_en = wr_en = 0.
  - Beat k addresses linear {row,col}, with col as the LSB nibble. Col increments and carries into row; 0xFF wraps to 0x00.
- BEAT, write sessions:
  - For k <= len_m1: if wdata_valid, drive wr = 1 and data = wdata, assert wdata_ready, and increment k.
  - If wdata_valid is low, drive an idle beat with wr = 0; it is not counted.
  - For k > len_m1 (padding): repeat the last real address and data with wr = 1. This is idempotent.
- BEAT, read sessions: drive rd = 1 every cycle, including padding beats (repeating the last address).
- Each active beat increments act_cnt. When act_cnt reaches SESSION_BEATS (after the 16th active beat), go to CLOSE.
- Read data timing:
  - rdata = mem_user_out.
  - rdata_valid is asserted in the cycle after each real (non-padding) read beat.
  - rdata_last is asserted with the len_m1-th beat's data.
  - There is no backpressure on read data.
- CLOSE (1 cycle): mem_enable = 1, rd/wr bits 0. The memory returns to idle.
- SETTLE (1 cycle): mem_enable = 1, rd_en = wr_en = 0. Then go to IDLE.
- Latency: a request accepted in cycle t gets OPEN at t+1 and first beat at t+2. A full-rate session is 20 cycles from acceptance until IDLE is re-entered.
- busy = 1 in OPEN through SETTLE; req_ready = 0 whenever busy.
- wdata_ready is never asserted outside write beats k <= len_m1.
- len_m1 = 15 means no padding. len_m1 = 0 means 15 padding beats.

Optional Feature:
- Macro NV_DDR_HOST_PWRDN_EN.
- With it defined:
  - Adds input pwr_dn_req and output sleeping.
  - When pwr_dn_req is sampled in IDLE (it has priority over req_valid), go to SLEEP.
  - SLEEP drives mem_enable = 0, mem_power_enable = 0, req_ready = 0, sleeping = 1.
  - SLEEP exits only on reset.
  - pwr_dn_req seen while busy is held pending and taken at the next IDLE.
- Without it: mem_power_enable is tied to 1, there is no SLEEP state, and neither port exists.

Decomposition:
- Package nv_ddr_pkg holds:
  - state encoding;
  - command-word bit positions (RD_BIT = 17, WR_BIT = 16, COL_MSB/LSB, ROW_MSB/LSB, DATA_MSB/LSB);
  - SESSION_BEATS default.
- One sub-module, nv_ddr_beat_gen, holds the linear address incrementer with wrap, beat_cnt, act_cnt, and padding/last detection.

Test Plan:
- Write burst, req_row = 2, req_col = 14, len_m1 = 2, data A1, A2, A3:
  - beats at (2,14), (2,15), (3,0), then 13 padding beats at (3,0) with A3;
  - a subsequent read of the same span returns A1, A2, A3 with rdata_last on A3.
- Full write of 16 beats from (15,15):
  - addresses wrap to (0,0) through (0,14);
  - no padding; CLOSE follows the 16th beat immediately.
- Write with wdata_valid low for 3 cycles mid-burst:
  - idle beats are inserted with wr = 0;
  - act_cnt still ends at exactly 16;
  - total session is 23 cycles.
- Read with len_m1 = 0 at (5,5):
  - exactly one rdata_valid, with last = 1;
  - 15 padding reads produce no valid.
- Assert rst low at beat 7 of a read:
  - all outputs return to reset values immediately;
  - next request proceeds normally.
- With NV_DDR_HOST_PWRDN_EN: pwr_dn_req during a session:
  - the session completes;
  - then SLEEP with mem_power_enable = 0 and req_ready = 0 until reset.
